// File: rtl/mc_ctrl_if.sv
// Handshake/control bundle between the instruction datapath and mc_ctrl_unit.
interface mc_ctrl_if #(
   parameter int OPW = 4
);
   logic [OPW-1:0] opcode;
   logic           zf, sf, cf;
   logic           mem_ready;
   logic [1:0]     op;
   logic           imm_sel, ld_sel, jmp_sel;
   logic           reg_en, pc_en, ir_en, mem_rd;
   logic           halted, err;
   logic [2:0]     state;

   modport master (
      output opcode, zf, sf, cf, mem_ready,
      input  op, imm_sel, ld_sel, jmp_sel, reg_en, pc_en, ir_en, mem_rd, halted, err, state
   );
   modport slave (
      input  opcode, zf, sf, cf, mem_ready,
      output op, imm_sel, ld_sel, jmp_sel, reg_en, pc_en, ir_en, mem_rd, halted, err, state
   );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle controller FSM: FETCH -> DECODE -> EXEC -> [MEM] -> WB, terminal HALT.
// Define MC_CTRL_MEM_TIMEOUT_EN to bound FETCH/MEM waits by TO_CYC cycles.
module mc_ctrl_unit #(
   parameter int OPW    = 4,
   parameter int TO_CYC = 15
) (
   input logic    clk,
   input logic    rst_n,
   mc_ctrl_if.slave bus
);
   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] HALT   = 3'd5;

   logic [2:0]     st_q, st_d;
   logic           act_q;
   logic [OPW-1:0] opc_q;
   logic           zf_q, sf_q, cf_q;
   logic           err_q, err_d;
   logic [3:0]     base;
   logic           illegal, is_ld, is_hlt, no_wr, taken;
   logic           imm_sel, ld_sel, jmp_sel, reg_en, pc_en, ir_en, mem_rd;

   // act_q holds every output low until the first edge after reset release.
   always_comb begin
      base    = opc_q[3:0];
      illegal = |(opc_q >> 4);
      is_ld   = (base == 4'h8);
      is_hlt  = (base == 4'hF);
      no_wr   = (base == 4'h1) || (base == 4'hD) || (base[3:2] == 2'b01);
      case (base)
         4'h4:    taken = zf_q & ~sf_q;
         4'h5:    taken = ~zf_q;
         4'h6:    taken = cf_q;
         4'h7:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
   logic [7:0] wcnt_q;
   logic       waiting, tmo;
   assign waiting = act_q && ((st_q == FETCH) || (st_q == MEM)) && !bus.mem_ready;
   assign tmo     = waiting && (wcnt_q == 8'(TO_CYC - 1));
`endif

   always_comb begin
      st_d    = st_q;
      err_d   = err_q;
      imm_sel = 1'b0;
      ld_sel  = 1'b0;
      jmp_sel = 1'b0;
      reg_en  = 1'b0;
      pc_en   = 1'b0;
      ir_en   = 1'b0;
      mem_rd  = 1'b0;
      if (act_q) begin
         case (st_q)
            FETCH: begin
               mem_rd = 1'b1;
               if (bus.mem_ready) begin
                  ir_en = 1'b1;
                  st_d  = DECODE;
               end
            end
            DECODE: st_d = EXEC;
            EXEC: begin
               if (illegal) begin
                  err_d = 1'b1;
                  st_d  = HALT;
               end else if (is_hlt) begin
                  st_d = HALT;
               end else begin
                  imm_sel = (base[3:2] == 2'b00);
                  st_d    = is_ld ? MEM : WB;
               end
            end
            MEM: begin
               mem_rd = 1'b1;
               ld_sel = 1'b1;
               if (bus.mem_ready) st_d = WB;
            end
            WB: begin
               pc_en   = 1'b1;
               reg_en  = ~no_wr;
               ld_sel  = is_ld;
               jmp_sel = taken;
               st_d    = FETCH;
            end
            HALT:    st_d = HALT;
            default: st_d = FETCH;
         endcase
`ifdef MC_CTRL_MEM_TIMEOUT_EN
         if (tmo) begin
            err_d = 1'b1;
            st_d  = HALT;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= FETCH;
         act_q <= 1'b0;
         opc_q <= '0;
         zf_q  <= 1'b0;
         sf_q  <= 1'b0;
         cf_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         act_q <= 1'b1;
         st_q  <= st_d;
         err_q <= err_d;
         // Flags are captured here so later ALU activity cannot alter the branch decision.
         if (act_q && (st_q == DECODE)) begin
            opc_q <= bus.opcode;
            zf_q  <= bus.zf;
            sf_q  <= bus.sf;
            cf_q  <= bus.cf;
         end
      end
   end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         wcnt_q <= '0;
      else if (!waiting || st_d != st_q)  wcnt_q <= '0;
      else                                wcnt_q <= wcnt_q + 8'd1;
   end
`endif

   assign bus.op      = opc_q[1:0];
   assign bus.imm_sel = imm_sel;
   assign bus.ld_sel  = ld_sel;
   assign bus.jmp_sel = jmp_sel;
   assign bus.reg_en  = reg_en;
   assign bus.pc_en   = pc_en;
   assign bus.ir_en   = ir_en;
   assign bus.mem_rd  = mem_rd;
   assign bus.halted  = (st_q == HALT);
   assign bus.err     = err_q;
   assign bus.state   = st_q;
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Random instruction stream against an opcode-class reference model; a scoreboard
// queue of expected WB/HALT events is drained by an independent monitor.
module tb_mc_ctrl_unit;
   localparam int OPW    = 6;
   localparam int TO_CYC = 15;
   localparam int NINS   = 60;
   localparam int BIG    = 32'h7fff_ffff;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mc_ctrl_if #(.OPW(OPW)) bus();
   mc_ctrl_unit #(.OPW(OPW), .TO_CYC(TO_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic       hlt, err, ir, imm, reg_en, ld, jmp;
      logic [1:0] op;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [13:0] outs();
      return {bus.op, bus.imm_sel, bus.ld_sel, bus.jmp_sel, bus.reg_en, bus.pc_en,
              bus.ir_en, bus.mem_rd, bus.halted, bus.err, bus.state};
   endfunction

   // Expected outcome of one instruction whose fetch request starts in cycle c0.
   function automatic exp_t model(input logic [OPW-1:0] opc, input logic z, s, c,
                                  input int c0, fw, mw);
      exp_t e;
      logic [3:0] b;
      b = opc[3:0];
      e = '{default: 0};
      e.ir = 1'b1;
      e.op = opc[1:0];
      if (TMO && fw >= TO_CYC) begin
         // never decoded: op still shows the cleared value from the preceding reset
         e.hlt = 1'b1; e.err = 1'b1; e.ir = 1'b0; e.op = 2'b00;
         e.cyc = c0 + TO_CYC;
      end else if ((opc >> 4) != 0) begin
         e.hlt = 1'b1; e.err = 1'b1; e.cyc = c0 + fw + 3;
      end else if (b == 4'hF) begin
         e.hlt = 1'b1; e.cyc = c0 + fw + 3;
      end else begin
         e.ld     = (b == 4'h8);
         e.imm    = (b < 4'h4);
         e.reg_en = !(b == 4'h1 || b == 4'hD || (b >= 4'h4 && b <= 4'h7));
         case (b)
            4'h4:    e.jmp = z && !s;
            4'h5:    e.jmp = !z;
            4'h6:    e.jmp = c;
            4'h7:    e.jmp = 1'b1;
            default: e.jmp = 1'b0;
         endcase
         e.cyc = c0 + fw + 3 + (e.ld ? mw + 1 : 0);
      end
      return e;
   endfunction

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1 chk("rst_async_outs", 32'(outs()), 0);
      bus.mem_ready = 1'b0;
      q.delete();
      @(negedge clk);
      #3 rst_n = 1'b1;
      #1 chk("rel_mem_rd_pre_edge", bus.mem_rd, 0);
      @(posedge clk);
      #1 chk("rel_mem_rd_first_edge", bus.mem_rd, 1);
   endtask

   // Stimulus: IR/flag driver plus memory responder keyed on mem_rd.
   initial begin
      logic [OPW-1:0] opc;
      logic z, s, c;
      int fw, mw, w, dec_at, hcyc, n_ins, idx;
      bit busy, phase, ld_now, abort, hpend;
      exp_t e;
      rst_n = 1'b0;
      bus.opcode = '0; bus.zf = 0; bus.sf = 0; bus.cf = 0; bus.mem_ready = 1'b0;
      #1 chk("reset_outs", 32'(outs()), 0);
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      #1 chk("first_mem_rd_pre_edge", bus.mem_rd, 0);
      @(posedge clk);
      #1 chk("first_mem_rd_edge", bus.mem_rd, 1);

      busy = 0; phase = 0; ld_now = 0; abort = 0; hpend = 0;
      n_ins = 0; idx = 0; w = 0; dec_at = BIG; hcyc = 0;
      while (!(n_ins >= NINS && q.size() == 0 && !busy) && cyc < 20000) begin
         @(negedge clk);
         if (hpend && cyc >= hcyc + 2) begin
            do_reset();
            busy = 0; phase = 0; hpend = 0; abort = 0; dec_at = BIG;
            continue;
         end
         if (cyc > dec_at) begin
            bus.opcode = OPW'($urandom);
            if (idx == 1) {bus.zf, bus.sf, bus.cf} = 3'b000;
            else          {bus.zf, bus.sf, bus.cf} = 3'($urandom);
         end
         if (bus.mem_rd) begin
            if (!busy) begin
               busy = 1;
               if (!phase) begin
                  idx = n_ins;
                  fw = $urandom_range(0, 3); mw = $urandom_range(0, 4); abort = 0;
                  {z, s, c} = 3'($urandom);
                  opc = '0;
                  opc[3:0] = 4'($urandom);
                  if ($urandom_range(0, 7) == 0) opc[OPW-1:4] = (OPW-4)'($urandom_range(1, (1 << (OPW-4)) - 1));
                  case (idx)
                     0: begin opc = '0; fw = 0; end
                     1: begin opc = OPW'(4); z = 1; s = 0; end
                     2: begin opc = OPW'(8); mw = 3; end
                     3: begin opc = OPW'(8); mw = 8; abort = 1; end
                     4: opc = OPW'(6'b010000);
                     5: begin opc = '0; fw = 20; end
                     default: ;
                  endcase
                  bus.opcode = opc; {bus.zf, bus.sf, bus.cf} = {z, s, c};
                  dec_at = BIG;
                  e = model(opc, z, s, c, cyc, fw, mw);
                  q.push_back(e);
                  if (e.hlt) begin hpend = 1; hcyc = e.cyc; end
                  ld_now = e.ld;
                  w = fw;
                  n_ins++;
               end else w = mw;
            end
            if (phase && abort && w == 4) begin
               do_reset();
               busy = 0; phase = 0; abort = 0; dec_at = BIG;
               continue;
            end
            bus.mem_ready = (w == 0);
            if (w == 0) begin
               busy = 0;
               if (!phase) begin dec_at = cyc + 1; phase = ld_now; end
               else phase = 0;
            end else w--;
         end else begin
            bus.mem_ready = 1'($urandom);
         end
      end
      chk("run_completed", 32'(n_ins >= NINS), 1);
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Monitor: pops one expected event per WB (pc_en) or HALT entry.
   initial begin
      int irc;
      bit imms, hprev;
      exp_t e;
      irc = 0; imms = 0; hprev = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin irc = 0; imms = 0; hprev = 0; continue; end
         if (bus.ir_en) begin irc++; chk("ir_reg_excl", bus.reg_en, 0); end
         if (bus.imm_sel) imms = 1;
         if (bus.reg_en) chk("reg_en_only_in_wb", bus.pc_en, 1);
         if (bus.halted)
            chk("halt_quiet", {bus.imm_sel, bus.ld_sel, bus.jmp_sel, bus.reg_en,
                               bus.pc_en, bus.ir_en, bus.mem_rd}, 0);
         if (bus.pc_en || (bus.halted && !hprev)) begin
            chk("event_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("evt_cycle", cyc, e.cyc);
               chk("evt_halted", bus.halted, e.hlt);
               chk("evt_err", bus.err, e.err);
               chk("evt_op", bus.op, e.op);
               chk("evt_ir_count", irc, e.ir);
               chk("evt_imm_sel", imms, e.imm);
               if (!e.hlt) begin
                  chk("wb_reg_en", bus.reg_en, e.reg_en);
                  chk("wb_ld_sel", bus.ld_sel, e.ld);
                  chk("wb_jmp_sel", bus.jmp_sel, e.jmp);
               end
            end
            irc = 0; imms = 0;
         end else if (q.size() > 0 && cyc > q[0].cyc) begin
            chk("evt_missing", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         hprev = bus.halted;
      end
   end
endmodule
